// File: rtl/reg_file_sb_if.sv
// Register-file access bundle: one write/issue side, two read ports with
// their pending flags, and the scoreboard occupancy count.
interface reg_file_sb_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic [DATA_WIDTH-1:0] in;
    logic [ADDR_WIDTH-1:0] inaddress;
    logic                  write;
    logic [ADDR_WIDTH-1:0] out1address;
    logic [ADDR_WIDTH-1:0] out2address;
    logic [DATA_WIDTH-1:0] out1;
    logic [DATA_WIDTH-1:0] out2;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] issue_address;
    logic                  out1_pending;
    logic                  out2_pending;
    logic [ADDR_WIDTH:0]   pending_count;

    modport master (
        output in, inaddress, write, out1address, out2address, issue, issue_address,
        input  out1, out2, out1_pending, out2_pending, pending_count
    );

    modport slave (
        input  in, inaddress, write, out1address, out2address, issue, issue_address,
        output out1, out2, out1_pending, out2_pending, pending_count
    );
endinterface

// File: rtl/reg_file_sb.sv
// Parametrised register file with two async read ports, one sync write port,
// optional write bypass / hardwired zero register, and a pending scoreboard.
module reg_file_sb_cell #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  iss_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  pend_q,
    output logic                  pend_d
);
    // Issue beats write: a newer producer is still in flight.
    always_comb begin
        pend_d = pend_q;
        if (iss_en)
            pend_d = 1'b1;
        else if (wr_en)
            pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data   <= '0;
            pend_q <= 1'b0;
        end else begin
            if (wr_en)
                data <= wdata;
            pend_q <= pend_d;
        end
    end
endmodule

module reg_file_sb #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int BYPASS     = 0,
    parameter int ZERO_REG   = 0
) (
    input  logic          clk,
    input  logic          reset,
    reg_file_sb_if.slave  bus
);
    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [NUM_REGS-1:0]                 wr_sel;
    logic [NUM_REGS-1:0]                 iss_sel;
    logic [NUM_REGS-1:0]                 pend_q;
    logic [NUM_REGS-1:0]                 pend_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic [ADDR_WIDTH:0]                 cnt_q;

    logic [1:0][ADDR_WIDTH-1:0] raddr;
    logic [1:0][DATA_WIDTH-1:0] rdata;
    logic [1:0]                 rpend;

    function automatic logic [ADDR_WIDTH:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [ADDR_WIDTH:0] s;
        s = '0;
        for (int i = 0; i < NUM_REGS; i++)
            s = s + {{ADDR_WIDTH{1'b0}}, v[i]};
        return s;
    endfunction

    // Register 0 is masked here so neither its data nor its pending bit can move.
    always_comb begin
        wr_sel                   = '0;
        iss_sel                  = '0;
        wr_sel[bus.inaddress]    = bus.write;
        iss_sel[bus.issue_address] = bus.issue;
        if (ZERO_REG != 0) begin
            wr_sel[0]  = 1'b0;
            iss_sel[0] = 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        reg_file_sb_cell #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_cell (
            .clk    (clk),
            .reset  (reset),
            .wr_en  (wr_sel[g]),
            .iss_en (iss_sel[g]),
            .wdata  (bus.in),
            .data   (regs[g]),
            .pend_q (pend_q[g]),
            .pend_d (pend_d[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= popcount(pend_d);
    end

    assign raddr[0] = bus.out1address;
    assign raddr[1] = bus.out2address;

    // Bypass reuses the masked write select, so address 0 never bypasses
    // under ZERO_REG; gating with reset keeps outputs at zero while held.
    always_comb begin
        rdata = '0;
        rpend = '0;
        for (int p = 0; p < 2; p++) begin
            if ((BYPASS != 0) && reset && wr_sel[raddr[p]]) begin
                rdata[p] = bus.in;
                rpend[p] = 1'b0;
            end else begin
                rdata[p] = regs[raddr[p]];
                rpend[p] = pend_q[raddr[p]];
            end
        end
    end

    assign bus.out1          = rdata[0];
    assign bus.out2          = rdata[1];
    assign bus.out1_pending  = rpend[0];
    assign bus.out2_pending  = rpend[1];
    assign bus.pending_count = cnt_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb across four configurations: plain, bypass,
// zero-register with bypass, and a 16x16 instance for the full scoreboard.
module tb_reg_file_sb;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    reg_file_sb_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(3)) b0 ();
    reg_file_sb_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(3)) b1 ();
    reg_file_sb_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(3)) b2 ();
    reg_file_sb_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) b3 ();

    reg_file_sb #(.DATA_WIDTH(8),  .ADDR_WIDTH(3), .BYPASS(0), .ZERO_REG(0))
        u0 (.clk(clk), .reset(reset), .bus(b0));
    reg_file_sb #(.DATA_WIDTH(8),  .ADDR_WIDTH(3), .BYPASS(1), .ZERO_REG(0))
        u1 (.clk(clk), .reset(reset), .bus(b1));
    reg_file_sb #(.DATA_WIDTH(8),  .ADDR_WIDTH(3), .BYPASS(1), .ZERO_REG(1))
        u2 (.clk(clk), .reset(reset), .bus(b2));
    reg_file_sb #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .BYPASS(0), .ZERO_REG(0))
        u3 (.clk(clk), .reset(reset), .bus(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  bi;
        logic [15:0] e;
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b0;
        b0.in = '0; b0.inaddress = '0; b0.write = 0; b0.out1address = '0; b0.out2address = '0; b0.issue = 0; b0.issue_address = '0;
        b1.in = '0; b1.inaddress = '0; b1.write = 0; b1.out1address = '0; b1.out2address = '0; b1.issue = 0; b1.issue_address = '0;
        b2.in = '0; b2.inaddress = '0; b2.write = 0; b2.out1address = '0; b2.out2address = '0; b2.issue = 0; b2.issue_address = '0;
        b3.in = '0; b3.inaddress = '0; b3.write = 0; b3.out1address = '0; b3.out2address = '0; b3.issue = 0; b3.issue_address = '0;

        // reset state
        #2;
        chk("rst_out1",  32'(b0.out1), 'h0);
        chk("rst_out2",  32'(b0.out2), 'h0);
        chk("rst_pend1", 32'(b0.out1_pending), 'h0);
        chk("rst_cnt",   32'(b0.pending_count), 'h0);
        #1 reset = 1'b1;

        // basic write / read
        step();
        b0.write = 1; b0.inaddress = 0; b0.in = 8'hFF;
        step();
        b0.inaddress = 2; b0.in = 8'h03;
        step();
        b0.write = 0; b0.out1address = 0; b0.out2address = 2;
        #1;
        chk("rd_r0",  32'(b0.out1), 'hFF);
        chk("rd_r2",  32'(b0.out2), 'h03);
        chk("rd_p1",  32'(b0.out1_pending), 'h0);
        chk("rd_p2",  32'(b0.out2_pending), 'h0);
        reset = 1'b0;
        #1;
        chk("async_rst_out1", 32'(b0.out1), 'h0);
        chk("async_rst_out2", 32'(b0.out2), 'h0);
        reset = 1'b1;

        // read during write, no bypass, both ports on one address
        step();
        b0.out1address = 5; b0.out2address = 5;
        b0.write = 1; b0.inaddress = 5; b0.in = 8'hA5;
        #1;
        chk("nobyp_before", 32'(b0.out1), 'h00);
        step();
        b0.write = 0;
        chk("nobyp_after",  32'(b0.out1), 'hA5);
        chk("same_addr_p2", 32'(b0.out2), 'hA5);

        // bypass
        b1.out1address = 5;
        b1.write = 1; b1.inaddress = 5; b1.in = 8'hA5;
        #1;
        chk("byp_same_cycle", 32'(b1.out1), 'hA5);
        chk("byp_pend",       32'(b1.out1_pending), 'h0);
        step();
        b1.write = 0;
        chk("byp_after", 32'(b1.out1), 'hA5);

        // scoreboard
        b0.out1address = 3; b0.out2address = 4;
        b0.issue = 1; b0.issue_address = 3;
        step();
        chk("sb_iss3_p1",  32'(b0.out1_pending), 'h1);
        chk("sb_iss3_cnt", 32'(b0.pending_count), 'h1);
        b0.issue_address = 4;
        step();
        b0.issue = 0;
        chk("sb_iss4_cnt", 32'(b0.pending_count), 'h2);
        chk("sb_iss4_p2",  32'(b0.out2_pending), 'h1);
        b0.write = 1; b0.inaddress = 3; b0.in = 8'h11;
        step();
        b0.write = 0;
        chk("sb_wr3_p1",  32'(b0.out1_pending), 'h0);
        chk("sb_wr3_cnt", 32'(b0.pending_count), 'h1);
        chk("sb_wr3_d",   32'(b0.out1), 'h11);
        b0.issue = 1; b0.issue_address = 4;
        step();
        chk("sb_reiss_cnt", 32'(b0.pending_count), 'h1);
        chk("sb_reiss_p2",  32'(b0.out2_pending), 'h1);

        // simultaneous issue + write
        b0.issue_address = 6;
        step();
        chk("iw_iss6_cnt", 32'(b0.pending_count), 'h2);
        b0.out1address = 6;
        b0.write = 1; b0.inaddress = 6; b0.in = 8'h22;
        step();
        chk("iw_same_d",   32'(b0.out1), 'h22);
        chk("iw_same_p",   32'(b0.out1_pending), 'h1);
        chk("iw_same_cnt", 32'(b0.pending_count), 'h2);
        b0.issue_address = 7; b0.inaddress = 4; b0.in = 8'h33;
        b0.out1address = 7;
        step();
        b0.issue = 0; b0.write = 0;
        chk("iw_diff_p7",  32'(b0.out1_pending), 'h1);
        chk("iw_diff_p4",  32'(b0.out2_pending), 'h0);
        chk("iw_diff_d4",  32'(b0.out2), 'h33);
        chk("iw_diff_cnt", 32'(b0.pending_count), 'h2);

        // zero register
        b2.out1address = 0; b2.out2address = 1;
        b2.write = 1; b2.inaddress = 0; b2.in = 8'h7E;
        b2.issue = 1; b2.issue_address = 0;
        #1;
        chk("z_nobyp", 32'(b2.out1), 'h00);
        step();
        b2.issue = 0;
        chk("z_out1", 32'(b2.out1), 'h00);
        chk("z_pend", 32'(b2.out1_pending), 'h0);
        chk("z_cnt",  32'(b2.pending_count), 'h0);
        b2.inaddress = 1; b2.in = 8'h5A;
        #1;
        chk("z_r1_byp", 32'(b2.out2), 'h5A);
        step();
        b2.write = 0;
        chk("z_r1", 32'(b2.out2), 'h5A);

        // full scoreboard, 16x16
        b3.issue = 1;
        for (int i = 0; i < 16; i++) begin
            b3.issue_address = 4'(i);
            step();
        end
        b3.issue = 0;
        chk("w_full_cnt", 32'(b3.pending_count), 'h10);
        b3.write = 1;
        for (int i = 0; i < 16; i++) begin
            bi = 8'(i);
            b3.inaddress = 4'(i);
            b3.in = {bi, bi};
            step();
        end
        b3.write = 0;
        chk("w_empty_cnt", 32'(b3.pending_count), 'h0);
        for (int i = 0; i < 16; i++) begin
            bi = 8'(15 - i);
            e  = {bi, bi};
            b3.out1address = 4'(i);
            b3.out2address = 4'(15 - i);
            #1;
            bi = 8'(i);
            chk("w_rd1", 32'(b3.out1), 32'({bi, bi}));
            chk("w_rd2", 32'(b3.out2), 32'(e));
        end
        b3.issue = 1; b3.issue_address = 3;
        step();
        b3.issue = 0;
        b3.out1address = 3;
        #1;
        chk("w_pre_rst_p", 32'(b3.out1_pending), 'h1);
        b3.write = 1; b3.inaddress = 3; b3.in = 16'hFFFF;
        reset = 1'b0;
        #1;
        chk("w_rst_d",   32'(b3.out1), 'h0);
        chk("w_rst_p",   32'(b3.out1_pending), 'h0);
        chk("w_rst_cnt", 32'(b3.pending_count), 'h0);
        step();
        chk("w_rst_hold", 32'(b3.out1), 'h0);
        b3.write = 0;
        reset = 1'b1;
        #2;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the 8x8 CPU register file.
- Two asynchronous read ports and one synchronous write port.
- Optional write-to-read bypass and optional hardwired-zero register 0.
- Per-register pending scoreboard so the control unit can detect read-after-write hazards. Sits between instruction decode and ALU in the single-cycle/early-pipelined CPU.

Parameters:
- DATA_WIDTH, 8, width of each register and data ports
- ADDR_WIDTH, 3, register address width; NUM_REGS = 2**ADDR_WIDTH
- BYPASS, 0, 1 = a read of the address being written this cycle returns `in`
- ZERO_REG, 0, 1 = register 0 always reads 0, and writes/issues to it are ignored

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 clears all state
- in  in  DATA_WIDTH  write data
- inaddress  in  ADDR_WIDTH  write address
- write  in  1  write enable, sampled at posedge clk
- out1address  in  ADDR_WIDTH  read port 1 address
- out2address  in  ADDR_WIDTH  read port 2 address
- out1  out  DATA_WIDTH  read port 1 data
- out2  out  DATA_WIDTH  read port 2 data
- issue  in  1  marks register issue_address as pending (result in flight)
- issue_address  in  ADDR_WIDTH  destination of issued instruction
- out1_pending  out  1  register at out1address is pending
- out2_pending  out  1  register at out2address is pending
- pending_count  out  ADDR_WIDTH+1  number of registers currently pending

Behaviour:
- Storage: NUM_REGS x DATA_WIDTH flops plus NUM_REGS pending bits.
- Reset:
  - reset=0 immediately (no clock) forces all registers and pending bits to 0.
  - Consequently out1=out2=0, out1_pending=out2_pending=0, pending_count=0 while reset is low.
  - Deassertion is independent of clk; the first write can occur at the first posedge after reset=1.
- Reset mid-operation: asserting reset in the same cycle as write/issue wins; nothing is stored.
- Write:
  - At posedge clk with reset=1 and write=1, reg[inaddress] <= in.
  - The same edge clears pending[inaddress].
- Read:
  - Combinational (zero-delay RTL): out1 = reg[out1address]; out2 = reg[out2address].
  - Without bypass, a read of the address being written shows the old value until the edge, the new value after it.
  - BYPASS=1: if write=1 and outNaddress==inaddress, outN = in in the same cycle, and outN_pending = 0.
  - Both ports may read the same address simultaneously.
- Issue:
  - At posedge with issue=1, pending[issue_address] <= 1.
  - Same edge, issue and write to the same address: pending ends 1 (issue wins; the newer producer is still outstanding) while the data is still written.
  - Same edge, different addresses: both actions take effect.
  - Issue to an already-pending register: stays 1, no error.
- pending_count:
  - Registered population count of the pending bits, updated at the same edge as the bits.
  - Range 0..NUM_REGS, hence the ADDR_WIDTH+1 width; it never wraps.
- ZERO_REG=1:
  - Writes to address 0 are discarded and issue to address 0 is ignored.
  - out1/out2 read 0 for address 0 and pending is never set for it.
  - Bypass never applies to address 0.
- Undefined inputs: none. All address values are legal because NUM_REGS is a power of two.

Test Plan:
1. Reset and basic write/read:
   - Stimulus: reset=0, then 1; write 8'hFF to r0 and 8'h03 to r2; read out1address=0, out2address=2.
   - Required: out1=FF, out2=03, both pending=0. Then pulse reset=0 between clock edges; out1=out2=00 immediately, with no clock edge needed.
2. Read-during-write:
   - BYPASS=0: write 8'hA5 to r5 while out1address=5 (old value 00); out1=00 before the edge, A5 after it.
   - BYPASS=1: out1=A5 in the same cycle as the write.
3. Scoreboard:
   - issue r3 -> out1_pending=1 (out1address=3), pending_count=1.
   - issue r4 -> pending_count=2.
   - write r3=8'h11 -> out1_pending=0, pending_count=1, out1=11.
4. Simultaneous issue+write to the same register:
   - With r6 pending, issue=1 and write=1 (in=8'h22) to r6 on one edge -> r6=22, pending[6]=1, pending_count unchanged.
5. ZERO_REG=1:
   - Write 8'h7E to r0 and issue r0 -> out1=00, out1_pending=0, pending_count=0.
   - Write to r1 works normally.
6. Full scoreboard and parametrisation:
   - DATA_WIDTH=16, ADDR_WIDTH=4: issue all 16 registers -> pending_count=16 (5'b10000).
   - Write each register with its index*0x0101 -> all reads correct and pending_count=0.
   - Assert reset mid-sequence -> everything returns to 0 asynchronously.
